// File: rtl/serializer_pkg.sv
// Shared types for the frame serializer.
package serializer_pkg;

    // IDLE: nothing on the line; SEND: shifter is presenting a frame bit
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_pending_reg.sv
// One-entry holding register for a frame that arrives while another is still
// being shifted out. A write sets the full flag, a take clears it.
module ser_pending_reg #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_take,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data,
    output logic [LEN_W-1:0]  o_len
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic [LEN_W-1:0]  r_len;

    // Capture on write, release on take; the owner never asserts both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_len  <= '0;
        end else if (i_wr) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_len  <= i_len;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_len  = r_len;

endmodule

// File: rtl/frame_serializer.sv
// Variable-length parallel-to-serial converter with a one-frame pending slot
// so consecutive frames leave the block with no idle cycle between them.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | shifter empty, outputs quiet, waiting for a non-empty frame
//   SEND  | shifter holds the frame whose current bit is on out_bit;
//         | r_rem counts bits still to present including the current one
module frame_serializer
    import serializer_pkg::*;
#(
    parameter int MAX_BITS  = 2401,
    parameter int LEN_W     = $clog2(MAX_BITS + 1),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MAX_BITS-1:0] in_data,
    input  logic [LEN_W-1:0]    in_len,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_bit,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last,
    output logic                busy
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    ser_state_t          r_state;
    ser_state_t          w_state_nxt;

    logic [MAX_BITS-1:0] r_shift;
    logic [LEN_W-1:0]    r_rem;
    logic                r_out_bit;
    logic                r_out_valid;
    logic                r_out_first;
    logic                r_out_last;
    logic                r_busy;

    logic                w_accept;
    logic                w_accept_nz;
    logic [LEN_W-1:0]    w_len_clamp;

    logic                w_pend_full;
    logic [MAX_BITS-1:0] w_pend_data;
    logic [LEN_W-1:0]    w_pend_len;
    logic                w_pend_wr;
    logic                w_pend_take;
    logic                w_pend_full_nxt;

    logic                w_load;
    logic                w_load_from_pend;
    logic                w_shift;
    logic [MAX_BITS-1:0] w_load_data;
    logic [LEN_W-1:0]    w_load_len;
    logic [MAX_BITS-1:0] w_shift_nxt;
    logic [LEN_W-1:0]    w_rem_nxt;
    logic                w_valid_nxt;
    logic                w_bit_nxt;
    logic                w_first_nxt;
    logic                w_last_nxt;
    logic                w_busy_nxt;

    // MSB-first frames are pushed to the top of the shifter so the first bit
    // always sits at MAX_BITS-1; unused upper input bits fall off the top.
    function automatic logic [MAX_BITS-1:0] align(input logic [MAX_BITS-1:0] d,
                                                  input logic [LEN_W-1:0]    len);
        if (MSB_FIRST)
            return d << (MAX_LEN - len);
        else
            return d;
    endfunction

    function automatic logic head_bit(input logic [MAX_BITS-1:0] v);
        return MSB_FIRST ? v[MAX_BITS-1] : v[0];
    endfunction

    function automatic logic [MAX_BITS-1:0] advance(input logic [MAX_BITS-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    assign in_ready    = !w_pend_full;
    assign w_accept    = in_valid && in_ready;
    assign w_len_clamp = (in_len > MAX_LEN) ? MAX_LEN : in_len;
    // Zero-length frames complete the handshake but are otherwise ignored.
    assign w_accept_nz = w_accept && (w_len_clamp != '0);

    ser_pending_reg #(
        .DATA_W (MAX_BITS),
        .LEN_W  (LEN_W)
    ) u_pending (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_wr   (w_pend_wr),
        .i_data (in_data),
        .i_len  (w_len_clamp),
        .i_take (w_pend_take),
        .o_full (w_pend_full),
        .o_data (w_pend_data),
        .o_len  (w_pend_len)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode plus load/shift/pending strobes and next output values.
    always_comb begin
        w_state_nxt      = r_state;
        w_load           = 1'b0;
        w_load_from_pend = 1'b0;
        w_shift          = 1'b0;
        w_pend_wr        = 1'b0;
        w_pend_take      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept_nz) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (r_rem > ONE) begin
                    w_shift   = 1'b1;
                    w_pend_wr = w_accept_nz;
                end else if (w_pend_full) begin
                    w_load           = 1'b1;
                    w_load_from_pend = 1'b1;
                    w_pend_take      = 1'b1;
                end else if (w_accept_nz) begin
                    // Bypass: the new frame goes straight into the shifter.
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_load_data = w_load_from_pend ? align(w_pend_data, w_pend_len)
                                       : align(in_data, w_len_clamp);
        w_load_len  = w_load_from_pend ? w_pend_len : w_len_clamp;

        if (w_load) begin
            w_shift_nxt = w_load_data;
            w_rem_nxt   = w_load_len;
        end else if (w_shift) begin
            w_shift_nxt = advance(r_shift);
            w_rem_nxt   = r_rem - ONE;
        end else if (w_state_nxt == IDLE) begin
            w_shift_nxt = '0;
            w_rem_nxt   = '0;
        end else begin
            w_shift_nxt = r_shift;
            w_rem_nxt   = r_rem;
        end

        w_pend_full_nxt = w_pend_wr || (w_pend_full && !w_pend_take);
        w_valid_nxt     = (w_state_nxt == SEND);
        w_bit_nxt       = w_valid_nxt && head_bit(w_shift_nxt);
        w_first_nxt     = w_load;
        w_last_nxt      = w_valid_nxt && (w_rem_nxt == ONE);
        w_busy_nxt      = w_valid_nxt || w_pend_full_nxt;
    end

    // Shifter, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_rem       <= '0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_rem       <= w_rem_nxt;
            r_out_bit   <= w_bit_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_first <= w_first_nxt;
            r_out_last  <= w_last_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign out_bit   = r_out_bit;
    assign out_valid = r_out_valid;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule
